// File: rtl/egr_rrq_arb.sv
// ----------------------------------------------------------------------------
// egr_rrq_arb
//
// Egress read-request arbiter. Several egress requesters share the single
// Mesh Read Interface read-request port. A round-robin arbiter picks one
// eligible requester per cycle and loads its request into a one-entry output
// register. Each requester also has an outstanding-read limit, and all of
// them together draw on a global pool of read credits. The requester index
// travels with each request so that the matching response can return the
// credit.
//
// Ports:
//   cclk              clock
//   rst               synchronous active-high reset
//   req_valid         per-requester request valid            [N_REQ]
//   req_addr          per-requester address, i at [i*ADDR_W +: ADDR_W]
//   req_ready         grant to a requester, one-hot or zero  [N_REQ]
//   mri_rreq_valid    read request valid toward MRI
//   mri_rreq_addr     read request address toward MRI        [ADDR_W]
//   mri_rreq_idx      requester index tag of the request     [IDX_W]
//   mri_rreq_ready    MRI accepts the held request
//   mri_rrsp_valid    MRI read response, returns one credit
//   mri_rrsp_idx      requester index of the response        [IDX_W]
//   glb_cred_avail    global credits currently available
//   err_rsp_underflow sticky: a response arrived for an idle requester
// ----------------------------------------------------------------------------
module egr_rrq_arb #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = 20,
    parameter int GLB_CRED = 16,
    parameter int REQ_MAX  = 8,
    parameter int IDX_W    = $clog2(N_REQ)
) (
    input  logic                          cclk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*ADDR_W-1:0]       req_addr,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          mri_rreq_valid,
    output logic [ADDR_W-1:0]             mri_rreq_addr,
    output logic [IDX_W-1:0]              mri_rreq_idx,
    input  logic                          mri_rreq_ready,
    input  logic                          mri_rrsp_valid,
    input  logic [IDX_W-1:0]              mri_rrsp_idx,
    output logic [$clog2(GLB_CRED+1)-1:0] glb_cred_avail,
    output logic                          err_rsp_underflow
);

    localparam int CRED_W = $clog2(GLB_CRED + 1);
    localparam int CNT_W  = $clog2(REQ_MAX + 1);

    // Architectural state
    logic [CNT_W-1:0]  r_outCnt [N_REQ];
    logic [CRED_W-1:0] r_glbCred;
    logic [IDX_W-1:0]  r_rrPtr;
    logic              r_outValid;
    logic [ADDR_W-1:0] r_outAddr;
    logic [IDX_W-1:0]  r_outIdx;
    logic              r_errUnderflow;

    // Combinational helpers
    logic              w_canLoad;
    logic [N_REQ-1:0]  w_eligible;
    logic              w_grantFound;
    logic [IDX_W-1:0]  w_grantIdx;
    logic [IDX_W-1:0]  w_cand;
    logic              w_accept;
    logic              w_rspOk;

    // The output register can take a new request when it is empty or when
    // its current request leaves toward MRI in this same cycle, which gives
    // one request per cycle while MRI stays ready.
    assign w_canLoad = !r_outValid || mri_rreq_ready;

    // A requester may be picked only while it has a request, is below its own
    // outstanding limit, and the global pool still has a credit. A request
    // sitting in the output register already owns its credit.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_eligible[i] = req_valid[i]
                            && (r_outCnt[i] < CNT_W'(REQ_MAX))
                            && (r_glbCred != '0);
        end
    end

    // Round-robin search: start at the pointer and walk upward. The walk wraps
    // naturally because N_REQ is a power of two and the candidate index is
    // exactly IDX_W bits wide. The first eligible requester found wins.
    always_comb begin
        w_grantFound = 1'b0;
        w_grantIdx   = '0;
        w_cand       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = r_rrPtr + IDX_W'(k);
            if (!w_grantFound && w_eligible[w_cand]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = w_cand;
            end
        end
    end

    // The grant is combinational. Requesters must not make req_valid depend
    // on req_ready, so no loop forms. No grant is given while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && w_canLoad && w_grantFound) begin
            req_ready[w_grantIdx] = 1'b1;
        end
    end

    assign w_accept = |(req_ready & req_valid);

    // A response returns a credit only if its requester really has a read
    // outstanding. Otherwise the counters stay as they are and the error
    // flag records the event.
    assign w_rspOk = mri_rrsp_valid && (r_outCnt[mri_rrsp_idx] != '0);

    // Per-requester outstanding counters. An accept and a response to the
    // same requester in one cycle cancel each other out.
    always_ff @(posedge cclk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_outCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                case ({w_accept && (w_grantIdx == IDX_W'(i)),
                       w_rspOk && (mri_rrsp_idx == IDX_W'(i))})
                    2'b10:   r_outCnt[i] <= r_outCnt[i] + 1'b1;
                    2'b01:   r_outCnt[i] <= r_outCnt[i] - 1'b1;
                    default: r_outCnt[i] <= r_outCnt[i];
                endcase
            end
        end
    end

    // Global credit pool. Credits are taken when a request is accepted from a
    // requester, not when MRI accepts it, and are returned on valid
    // responses.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_glbCred <= CRED_W'(GLB_CRED);
        end else begin
            case ({w_accept, w_rspOk})
                2'b10:   r_glbCred <= r_glbCred - 1'b1;
                2'b01:   r_glbCred <= r_glbCred + 1'b1;
                default: r_glbCred <= r_glbCred;
            endcase
        end
    end

    // The round-robin pointer moves just past the requester that was served.
    // It stays where it is in cycles without a grant.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_rrPtr <= '0;
        end else if (w_accept) begin
            r_rrPtr <= w_grantIdx + 1'b1;
        end
    end

    // One-entry output register toward MRI. It reloads on an accept, empties
    // when MRI takes the request and nothing new arrives, and otherwise holds
    // its contents stable under backpressure.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outAddr  <= '0;
            r_outIdx   <= '0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outAddr  <= req_addr[w_grantIdx*ADDR_W +: ADDR_W];
            r_outIdx   <= w_grantIdx;
        end else if (mri_rreq_ready) begin
            r_outValid <= 1'b0;
        end
    end

    // Sticky underflow flag. Only reset clears it. A response that arrives
    // after reset for a read issued before reset also sets it.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_errUnderflow <= 1'b0;
        end else if (mri_rrsp_valid && !w_rspOk) begin
            r_errUnderflow <= 1'b1;
        end
    end

    assign mri_rreq_valid    = r_outValid;
    assign mri_rreq_addr     = r_outAddr;
    assign mri_rreq_idx      = r_outIdx;
    assign glb_cred_avail    = r_glbCred;
    assign err_rsp_underflow = r_errUnderflow;

endmodule

// File: tb/tb_egr_rrq_arb.sv
// ----------------------------------------------------------------------------
// tb_egr_rrq_arb
//
// Self-checking bench for egr_rrq_arb. A behavioural reference model keeps
// outstanding counts, the credit pool, the round-robin pointer and the held
// request as plain integers. It predicts the grant and the registered outputs
// in every cycle. A short table of hand-derived vectors and a set of directed
// corner-case sequences are run first, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_egr_rrq_arb;

    localparam int N      = 4;
    localparam int AW     = 20;
    localparam int GLB    = 16;
    localparam int RMAX   = 8;
    localparam int IW     = $clog2(N);
    localparam int CW     = $clog2(GLB + 1);

    logic              cclk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic              mri_rreq_valid;
    logic [AW-1:0]     mri_rreq_addr;
    logic [IW-1:0]     mri_rreq_idx;
    logic              mri_rreq_ready;
    logic              mri_rrsp_valid;
    logic [IW-1:0]     mri_rrsp_idx;
    logic [CW-1:0]     glb_cred_avail;
    logic              err_rsp_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_cnt [N];
    int          m_cred;
    int          m_ptr;
    bit          m_valid;
    logic [AW-1:0] m_addr;
    int          m_idx;
    bit          m_err;
    logic [N-1:0] m_grant;
    int          lastAccept;

    typedef struct {
        logic [N-1:0]  valid;
        logic          mready;
        logic          rspV;
        logic [IW-1:0] rspIdx;
        logic [N-1:0]  expReady;
        logic          expMValid;
        logic [IW-1:0] expIdx;
        logic [CW-1:0] expCred;
    } vec_t;

    vec_t tbl [10];

    egr_rrq_arb #(
        .N_REQ    (N),
        .ADDR_W   (AW),
        .GLB_CRED (GLB),
        .REQ_MAX  (RMAX)
    ) dut (
        .cclk              (cclk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .mri_rreq_valid    (mri_rreq_valid),
        .mri_rreq_addr     (mri_rreq_addr),
        .mri_rreq_idx      (mri_rreq_idx),
        .mri_rreq_ready    (mri_rreq_ready),
        .mri_rrsp_valid    (mri_rrsp_valid),
        .mri_rrsp_idx      (mri_rrsp_idx),
        .glb_cred_avail    (glb_cred_avail),
        .err_rsp_underflow (err_rsp_underflow)
    );

    always #5 cclk = ~cclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_cred  = GLB;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_idx   = 0;
        m_err   = 1'b0;
    endtask

    // The requester that is served is the eligible one at the smallest
    // circular distance from the pointer.
    function automatic logic [N-1:0] modelGrant(logic r, logic [N-1:0] v, logic mready);
        int best;
        int bestDist;
        int d;
        logic [N-1:0] g;
        g = '0;
        best = -1;
        bestDist = N;
        if (r || (m_valid && !mready) || m_cred == 0) return g;
        for (int i = 0; i < N; i++) begin
            if (v[i] && m_cnt[i] < RMAX) begin
                d = (i - m_ptr + N) % N;
                if (d < bestDist) begin
                    bestDist = d;
                    best = i;
                end
            end
        end
        if (best >= 0) g[best] = 1'b1;
        return g;
    endfunction

    // Drive one cycle of inputs away from the rising edge, let the logic
    // settle, then compare everything against the model.
    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic mr,
                                 input logic rv, input logic [IW-1:0] ri);
        @(negedge cclk);
        rst            = r;
        req_valid      = v;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
        mri_rreq_ready = mr;
        mri_rrsp_valid = rv;
        mri_rrsp_idx   = ri;
        #1;
        m_grant = modelGrant(r, v, mr);
        lastAccept = (|(req_ready & req_valid)) ? 1 : 0;
        checkOutput("req_ready", 32'(req_ready), 32'(m_grant));
        checkOutput("mri_rreq_valid", 32'(mri_rreq_valid), 32'(m_valid));
        if (m_valid) begin
            checkOutput("mri_rreq_addr", 32'(mri_rreq_addr), 32'(m_addr));
            checkOutput("mri_rreq_idx", 32'(mri_rreq_idx), 32'(m_idx));
        end
        checkOutput("glb_cred_avail", 32'(glb_cred_avail), 32'(m_cred));
        checkOutput("err_rsp_underflow", 32'(err_rsp_underflow), 32'(m_err));
    endtask

    // Advance the model across the rising edge by using the inputs that were
    // applied in this cycle.
    task automatic clockModel();
        bit rspOk;
        int gi;
        @(posedge cclk);
        if (rst) begin
            modelReset();
        end else begin
            rspOk = mri_rrsp_valid && (m_cnt[mri_rrsp_idx] > 0);
            if (mri_rrsp_valid && !rspOk) m_err = 1'b1;
            if (m_grant != '0) begin
                gi = 0;
                for (int i = 0; i < N; i++) if (m_grant[i]) gi = i;
                m_valid = 1'b1;
                m_addr  = req_addr[gi*AW +: AW];
                m_idx   = gi;
                m_cnt[gi]++;
                m_cred--;
                m_ptr = (gi + 1) % N;
            end else if (mri_rreq_ready) begin
                m_valid = 1'b0;
            end
            if (rspOk) begin
                m_cnt[mri_rrsp_idx]--;
                m_cred++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] v, input logic mr,
                       input logic rv, input logic [IW-1:0] ri);
        applyStimulus(r, v, mr, rv, ri);
        clockModel();
    endtask

    initial begin
        int acc;
        logic [N-1:0] rv;
        logic [IW-1:0] ri;
        logic rvalid;

        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        mri_rreq_ready = 1'b0;
        mri_rrsp_valid = 1'b0;
        mri_rrsp_idx = '0;
        repeat (2) @(posedge cclk);
        modelReset();

        // Hand-derived vectors: round-robin, backpressure, response, drain
        tbl[0] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 5'd16};
        tbl[1] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd0, 5'd15};
        tbl[2] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 2'd1, 5'd14};
        tbl[3] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd2, 5'd13};
        tbl[4] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd3, 5'd12};
        tbl[5] = '{4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 5'd11};
        tbl[6] = '{4'hF, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 5'd11};
        tbl[7] = '{4'hF, 1'b1, 1'b1, 2'd0, 4'b0010, 1'b1, 2'd0, 5'd11};
        tbl[8] = '{4'h0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 2'd1, 5'd11};
        tbl[9] = '{4'h4, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 2'd1, 5'd11};

        $display("[TB] table vectors");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        for (int t = 0; t < 10; t++) begin
            applyStimulus(1'b0, tbl[t].valid, tbl[t].mready, tbl[t].rspV, tbl[t].rspIdx);
            checkOutput("tbl_ready", 32'(req_ready), 32'(tbl[t].expReady));
            checkOutput("tbl_mvalid", 32'(mri_rreq_valid), 32'(tbl[t].expMValid));
            if (tbl[t].expMValid) checkOutput("tbl_idx", 32'(mri_rreq_idx), 32'(tbl[t].expIdx));
            checkOutput("tbl_cred", 32'(glb_cred_avail), 32'(tbl[t].expCred));
            clockModel();
        end

        $display("[TB] global credit exhaustion");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, '0);
            acc += lastAccept;
            clockModel();
        end
        checkOutput("exh_accepts", 32'(acc), 32'd16);
        applyStimulus(1'b0, 4'hF, 1'b1, 1'b1, 2'd1);
        checkOutput("exh_ready_zero", 32'(req_ready), 32'd0);
        checkOutput("exh_cred_zero", 32'(glb_cred_avail), 32'd0);
        clockModel();
        acc = 0;
        applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, '0);
        checkOutput("exh_regrant", 32'(|req_ready), 32'd1);
        acc += lastAccept;
        clockModel();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 4'hF, 1'b1, 1'b0, '0);
            acc += lastAccept;
            clockModel();
        end
        checkOutput("exh_one_more", 32'(acc), 32'd1);

        $display("[TB] per-requester limit");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0, '0);
            acc += lastAccept;
            clockModel();
        end
        checkOutput("lim_accepts", 32'(acc), 32'd8);
        applyStimulus(1'b0, 4'b1000, 1'b1, 1'b1, 2'd3);
        checkOutput("lim_cred", 32'(glb_cred_avail), 32'd8);
        checkOutput("lim_stall", 32'(req_ready), 32'd0);
        clockModel();
        applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0, '0);
        checkOutput("lim_regrant", 32'(req_ready), 32'b1000);
        clockModel();
        applyStimulus(1'b0, 4'b1001, 1'b1, 1'b0, '0);
        checkOutput("lim_other", 32'(req_ready), 32'b0001);
        clockModel();

        $display("[TB] backpressure");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0, '0);
            if (c > 0) begin
                checkOutput("bp_ready_zero", 32'(req_ready), 32'd0);
                checkOutput("bp_held_idx", 32'(mri_rreq_idx), 32'd2);
            end
            acc += lastAccept;
            clockModel();
        end
        checkOutput("bp_accepts", 32'(acc), 32'd1);
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, '0);
        checkOutput("bp_reload", 32'(req_ready), 32'b0100);
        clockModel();
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, '0);
        checkOutput("bp_b2b_valid", 32'(mri_rreq_valid), 32'd1);
        clockModel();

        $display("[TB] simultaneous events and underflow");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        cyc(1'b0, 4'b0010, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 4'b0010, 1'b1, 1'b1, 2'd1);
        checkOutput("sim_cred_before", 32'(glb_cred_avail), 32'd15);
        clockModel();
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, '0);
        checkOutput("sim_cred_after", 32'(glb_cred_avail), 32'd15);
        clockModel();
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 2'd0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, '0);
            checkOutput("uf_sticky", 32'(err_rsp_underflow), 32'd1);
            checkOutput("uf_cred", 32'(glb_cred_avail), 32'd15);
            clockModel();
        end
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, '0);
        checkOutput("uf_cleared", 32'(err_rsp_underflow), 32'd0);
        clockModel();

        $display("[TB] reset mid-operation");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 10; c++) cyc(1'b0, 4'hF, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, '0);
        checkOutput("rst_pre_cred", 32'(glb_cred_avail), 32'd6);
        clockModel();
        cyc(1'b1, 4'hF, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 4'b0110, 1'b1, 1'b0, '0);
        checkOutput("rst_mvalid", 32'(mri_rreq_valid), 32'd0);
        checkOutput("rst_cred", 32'(glb_cred_avail), 32'd16);
        checkOutput("rst_first_grant", 32'(req_ready), 32'b0010);
        clockModel();
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, '0);
        checkOutput("rst_stale_rsp", 32'(err_rsp_underflow), 32'd1);
        clockModel();

        $display("[TB] randomized run");
        cyc(1'b1, '0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 3000; c++) begin
            rv = N'($urandom);
            ri = IW'($urandom_range(0, N - 1));
            rvalid = ($urandom_range(0, 1) == 1);
            if (rvalid && m_cnt[ri] == 0 && $urandom_range(0, 19) != 0) rvalid = 1'b0;
            cyc(($urandom_range(0, 399) == 0), rv, ($urandom_range(0, 3) != 0), rvalid, ri);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
